// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory request interface: store sizes,
// load types and the responder FSM state.
package mips_mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_lane_fmt.sv
// Little-endian byte-lane formatting: store merge into an old word and
// load extraction with sign/zero extension.
module dm_lane_fmt
  import mips_mem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  wsize_i,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o,
  output logic [31:0] loaded_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Store merge: only the addressed lanes change; size 11 behaves as word.
  always_comb begin
    merged_o = old_word_i;
    case (wsize_i)
      SZ_BYTE: begin
        for (int k = 0; k < 4; k++) begin
          if (addr_lo_i == 2'(k)) merged_o[8*k +: 8] = wdata_i[7:0];
        end
      end
      SZ_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

  // Load extract; unknown load types behave as lw.
  always_comb begin
    byte_c   = 8'(old_word_i >> {addr_lo_i, 3'b000});
    half_c   = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    loaded_o = old_word_i;
    case (ld_type_i)
      LD_H:    loaded_o = {{16{half_c[15]}}, half_c};
      LD_HU:   loaded_o = {16'h0000, half_c};
      LD_B:    loaded_o = {{24{byte_c[7]}}, byte_c};
      LD_BU:   loaded_o = {24'h000000, byte_c};
      default: loaded_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Handshaked, fixed-latency data-memory slave (IDLE -> BUSY -> RESP).
// Optional misalignment trap and err port under DM_MISALIGN_TRAP_EN.
module dm_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemR,
  input  logic        MemWr,
  input  logic [1:0]  MemWrBits,
  input  logic [2:0]  MemRBits,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        rsp_valid,
  output logic [31:0] ReadData
`ifdef DM_MISALIGN_TRAP_EN
  , output logic      err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  dm_state_e       state_q;
  logic            rd_q;
  logic            wr_q;
  logic [1:0]      wsize_q;
  logic [2:0]      ld_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     data_q;
  logic [CW-1:0]   cnt_q;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   idx_c;
  logic [31:0]     word_c;
  logic [31:0]     merged_c;
  logic [31:0]     loaded_c;
  logic            commit_c;
  logic            mis_c;
  logic            unused_addr_c;

  assign unused_addr_c = ^addr[31:AW+2];
  assign idx_c         = addr_q[AW+1:2];
  assign word_c        = mem[idx_c];
  assign commit_c      = (state_q == BUSY) && (cnt_q == '0);

  dm_lane_fmt u_fmt (
    .old_word_i (word_c),
    .wdata_i    (data_q),
    .wsize_i    (wsize_q),
    .ld_type_i  (ld_q),
    .addr_lo_i  (addr_q[1:0]),
    .merged_o   (merged_c),
    .loaded_o   (loaded_c)
  );

`ifdef DM_MISALIGN_TRAP_EN
  // Halves need addr[0]=0, words need addr[1:0]=0; bytes never trap.
  always_comb begin
    mis_c = 1'b0;
    if (wr_q) begin
      case (wsize_q)
        SZ_HALF: mis_c = addr_q[0];
        SZ_BYTE: mis_c = 1'b0;
        default: mis_c = |addr_q[1:0];
      endcase
    end else begin
      case (ld_q)
        LD_H, LD_HU: mis_c = addr_q[0];
        LD_B, LD_BU: mis_c = 1'b0;
        default:     mis_c = |addr_q[1:0];
      endcase
    end
  end
`else
  assign mis_c = 1'b0;
`endif

  // Array write; reset on the commit edge suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && commit_c && wr_q && !mis_c) mem[idx_c] <= merged_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      ReadData  <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wsize_q   <= SZ_WORD;
      ld_q      <= LD_W;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef DM_MISALIGN_TRAP_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && (MemR || MemWr)) begin
            rd_q      <= MemR && !MemWr;
            wr_q      <= MemWr;
            wsize_q   <= MemWrBits;
            ld_q      <= MemRBits;
            addr_q    <= addr[AW+1:0];
            data_q    <= data;
            cnt_q     <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            rsp_valid <= 1'b1;
            ReadData  <= (rd_q && !mis_c) ? loaded_c : 32'h0;
`ifdef DM_MISALIGN_TRAP_EN
            err       <= mis_c;
`endif
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          ReadData  <= '0;
`ifdef DM_MISALIGN_TRAP_EN
          err       <= 1'b0;
`endif
          req_ready <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Randomized self-checking bench for dm_responder against a byte-array model.
module tb_dm_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LAT     = 2;
  localparam int unsigned NBYTES  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        MemR;
  logic        MemWr;
  logic [1:0]  MemWrBits;
  logic [2:0]  MemRBits;
  logic [31:0] addr;
  logic [31:0] data;
  logic        rsp_valid;
  logic [31:0] ReadData;
`ifdef DM_MISALIGN_TRAP_EN
  logic        err;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  mb [NBYTES];
  bit          exp_err;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemR      (MemR),
    .MemWr     (MemWr),
    .MemWrBits (MemWrBits),
    .MemRBits  (MemRBits),
    .addr      (addr),
    .data      (data),
    .rsp_valid (rsp_valid),
    .ReadData  (ReadData)
`ifdef DM_MISALIGN_TRAP_EN
    , .err     (err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array.
  function automatic logic [31:0] model_access(input bit r, input bit w, input logic [1:0] ws,
                                               input logic [2:0] ld, input logic [31:0] a,
                                               input logic [31:0] d);
    int unsigned ba = a % NBYTES;
    int unsigned n;
    int unsigned base;
    bit          sgn = 1'b0;
    longint      val = 0;
    exp_err = 1'b0;
    if (w) n = (ws == 2'b01) ? 2 : (ws == 2'b10) ? 1 : 4;
    else begin
      case (ld)
        3'b001: begin n = 2; sgn = 1'b1; end
        3'b010: n = 2;
        3'b011: begin n = 1; sgn = 1'b1; end
        3'b100: n = 1;
        default: n = 4;
      endcase
    end
`ifdef DM_MISALIGN_TRAP_EN
    if (ba % n != 0) begin
      exp_err = 1'b1;
      return 32'h0;
    end
`endif
    base = ba - (ba % n);
    if (w) begin
      for (int i = 0; i < int'(n); i++) mb[base + i] = 8'(d >> (8 * i));
      return 32'h0;
    end
    if (!r) return 32'h0;
    for (int i = 0; i < int'(n); i++) val = val + (longint'(mb[base + i]) << (8 * i));
    if (sgn && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
    return 32'(val);
  endfunction

  task automatic drive(input bit r, input bit w, input logic [1:0] ws, input logic [2:0] ld,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; MemR = r; MemWr = w; MemWrBits = ws; MemRBits = ld; addr = a; data = d;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; MemR = 1'b0; MemWr = 1'b0; MemWrBits = 2'b00; MemRBits = 3'b000;
    addr = 32'h0; data = 32'h0;
  endtask

  // Called right after the accept edge; ends at a negedge with the DUT back in IDLE.
  task automatic wait_rsp(input string tag, input logic [31:0] exp_rd, input bit exp_e);
    int n = 0;
    for (int i = 1; i <= int'(LAT) + 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) begin n = i; break; end
      chk({tag, " ready_busy"}, 32'(req_ready), 32'h0);
    end
    chk({tag, " latency"}, 32'(n), 32'(LAT));
    if (n == 0) return;
    chk({tag, " rdata"}, ReadData, exp_rd);
    chk({tag, " ready_resp"}, 32'(req_ready), 32'h0);
`ifdef DM_MISALIGN_TRAP_EN
    chk({tag, " err"}, 32'(err), 32'(exp_e));
`else
    if (exp_e) chk({tag, " err_unexpected"}, 32'h1, 32'h0);
`endif
    @(posedge clk); @(negedge clk);
    chk({tag, " rsp_drop"}, 32'(rsp_valid), 32'h0);
    chk({tag, " ready_idle"}, 32'(req_ready), 32'h1);
  endtask

  task automatic do_req(input string tag, input bit r, input bit w, input logic [1:0] ws,
                        input logic [2:0] ld, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin chk({tag, " ready_wait"}, 32'(req_ready), 32'h1); return; end
    exp_rd = model_access(r, w, ws, ld, a, d);
    drive(r, w, ws, ld, a, d);
    @(posedge clk); #1 idle_inputs();
    wait_rsp(tag, exp_rd, exp_err);
  endtask

  // Store aborted by reset asserted after `pre` BUSY edges (pre=LAT-1 hits the commit edge).
  task automatic reset_abort(input string tag, input int pre);
    drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h40, 32'h1111_1111);
    @(posedge clk); #1 idle_inputs();
    repeat (pre) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'h1);
    chk({tag, " rsp"}, 32'(rsp_valid), 32'h0);
    chk({tag, " rdata"}, ReadData, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, " no_rsp"}, 32'(rsp_valid), 32'h0);
    end
    do_req({tag, " lw_old"}, 1'b1, 1'b0, 2'b00, 3'b000, 32'h40, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_a;
    for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'h00;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'h1);
    chk("reset rsp", 32'(rsp_valid), 32'h0);
    chk("reset rdata", ReadData, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Bring the exercised region to the zero state the model assumes.
    for (int i = 0; i < 64; i++) do_req("zero", 1'b0, 1'b1, 2'b00, 3'b000, 32'(i * 4), 32'h0);

    do_req("sw 40", 1'b0, 1'b1, 2'b00, 3'b000, 32'h40, 32'hDEAD_BEEF);
    do_req("lw 40", 1'b1, 1'b0, 2'b00, 3'b000, 32'h40, 32'h0);
    reset_abort("rst_busy", 0);
    reset_abort("rst_commit", int'(LAT) - 1);

    do_req("sw 10", 1'b0, 1'b1, 2'b00, 3'b000, 32'h10, 32'h0);
    do_req("sb 13", 1'b0, 1'b1, 2'b10, 3'b000, 32'h13, 32'h0000_00A5);
    do_req("lw 10a", 1'b1, 1'b0, 2'b00, 3'b000, 32'h10, 32'h0);
    chk("sb const", model_access(1'b1, 1'b0, 2'b00, 3'b000, 32'h10, 32'h0), 32'hA500_0000);
    do_req("sh 10", 1'b0, 1'b1, 2'b01, 3'b000, 32'h10, 32'hFFFF_1234);
    do_req("lw 10b", 1'b1, 1'b0, 2'b00, 3'b000, 32'h10, 32'h0);
    chk("sh const", model_access(1'b1, 1'b0, 2'b00, 3'b000, 32'h10, 32'h0), 32'hA500_1234);

    do_req("sw 20", 1'b0, 1'b1, 2'b00, 3'b000, 32'h20, 32'h0000_8080);
    do_req("lb 20", 1'b1, 1'b0, 2'b00, 3'b011, 32'h20, 32'h0);
    do_req("lbu 20", 1'b1, 1'b0, 2'b00, 3'b100, 32'h20, 32'h0);
    do_req("lh 20", 1'b1, 1'b0, 2'b00, 3'b001, 32'h20, 32'h0);
    do_req("lhu 20", 1'b1, 1'b0, 2'b00, 3'b010, 32'h20, 32'h0);
    chk("lb const", model_access(1'b1, 1'b0, 2'b00, 3'b011, 32'h20, 32'h0), 32'hFFFF_FF80);
    chk("lh const", model_access(1'b1, 1'b0, 2'b00, 3'b001, 32'h20, 32'h0), 32'hFFFF_8080);

    // Request held during BUSY/RESP must wait for IDLE; the latched read is used.
    exp_a = model_access(1'b1, 1'b0, 2'b00, 3'b000, 32'h40, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h40, 32'h0);
    @(posedge clk); #1 drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h80, 32'hCAFE_F00D);
    wait_rsp("held A", exp_a, 1'b0);
    void'(model_access(1'b0, 1'b1, 2'b00, 3'b000, 32'h80, 32'hCAFE_F00D));
    @(posedge clk); #1 idle_inputs();
    wait_rsp("held B", 32'h0, 1'b0);
    do_req("lw 80", 1'b1, 1'b0, 2'b00, 3'b000, 32'h80, 32'h0);

    // Valid without MemR/MemWr is ignored.
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("null rsp", 32'(rsp_valid), 32'h0);
      chk("null ready", 32'(req_ready), 32'h1);
    end
    idle_inputs();

    do_req("sw alias", 1'b0, 1'b1, 2'b00, 3'b000, 32'(DEPTH * 4 + 8), 32'h5A5A_1234);
    do_req("lw 8", 1'b1, 1'b0, 2'b00, 3'b000, 32'h8, 32'h0);

    do_req("sw 42", 1'b0, 1'b1, 2'b00, 3'b000, 32'h42, 32'h0BAD_0BAD);
    do_req("lw 40c", 1'b1, 1'b0, 2'b00, 3'b000, 32'h40, 32'h0);

    for (int t = 0; t < 300; t++) begin
      bit          r  = 1'($urandom());
      bit          w  = 1'($urandom());
      logic [31:0] a  = ($urandom() << 12) | 32'($urandom_range(0, 255));
      do_req("rand", r, w, 2'($urandom()), 3'($urandom_range(0, 7)), a, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
